// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// default memory latency and latency-counter width.
package mem_arb_pkg;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker; remembers which master was served last and
// favours the other one when both request.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] pick
);

    logic last;  // 1 = m1 served last, so m0 wins the first tie after reset

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update && (|req)) begin
            last <= pick[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, single-outstanding memory arbiter: latches the winner's command,
// issues one memory strobe, waits MEM_LAT cycles and returns a one-cycle ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m0_half,
    input  logic          m1_half,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_half,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic          busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         req;
    logic [1:0]         pick;
    logic               arb;
    logic               cmd_we;
    logic               cmd_half;
    logic [AW-1:0]      cmd_addr;
    logic [DW-1:0]      cmd_wdata;

    assign req = {m1_req, m0_req};

    mem_arb_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (arb),
        .pick   (pick)
    );

    always_comb begin
        state_nxt = state;
        arb       = 1'b0;
        mem_en    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    arb       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                state_nxt = (MEM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                m0_ack    = grant[0];
                m1_ack    = grant[1];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we    = mem_en & cmd_we;
    assign mem_half  = cmd_half;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            grant    <= 2'b00;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE:    if (arb) grant <= pick;
                ISSUE:   cnt <= CNT_W'(MEM_LAT - 1);
                WAIT:    cnt <= cnt - 1'b1;
                DONE:    grant <= 2'b00;
                default: grant <= 2'b00;
            endcase
            // read data is sampled on the edge that enters DONE
            if ((state_nxt == DONE) && (state != DONE) && !cmd_we) begin
                if (grant[0]) m0_rdata <= mem_rdata;
                if (grant[1]) m1_rdata <= mem_rdata;
            end
        end
    end

    // command is captured once at arbitration and held through DONE
    always_ff @(posedge clk) begin
        if (arb) begin
            cmd_we    <= pick[1] ? m1_we    : m0_we;
            cmd_half  <= pick[1] ? m1_half  : m0_half;
            cmd_addr  <= pick[1] ? m1_addr  : m0_addr;
            cmd_wdata <= pick[1] ? m1_wdata : m0_wdata;
        end
    end

endmodule
